// File: rtl/arbitro_salida.sv
// ---------------------------------------------------------------------------
// arbitro_salida
// Read side of the routing arbiter. Drains four show-ahead class FIFOs
// round-robin, one word per cycle, into a single output FIFO, honouring the
// output FIFO's almost-full flag. Keeps a wrapping per-source word counter so
// the forwarded word counts can be compared against the write-side push
// counts.
//
// Ports
//   clk                 single clock, all state updates on posedge
//   reset_L             synchronous active-low reset
//   fifoN_data          head word of source FIFO N (valid while fifoN_empty=0)
//   fifoN_empty         empty flag of source FIFO N
//   out_almost_full     almost-full flag of the output FIFO
//   popN                combinational pop strobe to source FIFO N (one-hot or 0)
//   push_out            registered write strobe to the output FIFO
//   data_out            registered word to the output FIFO
//   contN               words forwarded from source N (wraps)
//   idle                high while the registered state is IDLE
// ---------------------------------------------------------------------------
module arbitro_salida #(
   parameter int DATA_SIZE = 12,
   parameter int CNT_SIZE  = 5
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic [DATA_SIZE-1:0] fifo0_data,
   input  logic [DATA_SIZE-1:0] fifo1_data,
   input  logic [DATA_SIZE-1:0] fifo2_data,
   input  logic [DATA_SIZE-1:0] fifo3_data,
   input  logic                 fifo0_empty,
   input  logic                 fifo1_empty,
   input  logic                 fifo2_empty,
   input  logic                 fifo3_empty,
   input  logic                 out_almost_full,
   output logic                 pop0,
   output logic                 pop1,
   output logic                 pop2,
   output logic                 pop3,
   output logic                 push_out,
   output logic [DATA_SIZE-1:0] data_out,
   output logic [CNT_SIZE-1:0]  cont0,
   output logic [CNT_SIZE-1:0]  cont1,
   output logic [CNT_SIZE-1:0]  cont2,
   output logic [CNT_SIZE-1:0]  cont3,
   output logic                 idle
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_BLOCKED = 2'd2
   } state_t;

   state_t               r_state;
   logic [1:0]           r_rr;
   logic                 r_push;
   logic [DATA_SIZE-1:0] r_data;
   logic [CNT_SIZE-1:0]  r_cont [4];

   logic [3:0]           w_nonEmpty;
   logic [3:0]           w_eligible;
   logic [3:0]           w_grant;
   logic [1:0]           w_grantIdx;
   logic [1:0]           w_probe;
   logic                 w_found;
   logic [DATA_SIZE-1:0] w_grantData;

   assign w_nonEmpty = ~{fifo3_empty, fifo2_empty, fifo1_empty, fifo0_empty};

   // Gating eligibility with reset_L kills any pop during a reset cycle, even
   // mid-stream, so source FIFOs keep their contents across a reset.
   assign w_eligible = (reset_L && !out_almost_full) ? w_nonEmpty : 4'b0000;

   // Round-robin search starting at the pointer; the 2-bit add wraps mod 4.
   always_comb begin
      w_found    = 1'b0;
      w_grantIdx = r_rr;
      w_probe    = r_rr;
      w_grant    = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         w_probe = r_rr + 2'(k);
         if (!w_found && w_eligible[w_probe]) begin
            w_found    = 1'b1;
            w_grantIdx = w_probe;
         end
      end
      if (w_found) begin
         w_grant[w_grantIdx] = 1'b1;
      end
   end

   always_comb begin
      case (w_grantIdx)
         2'd0:    w_grantData = fifo0_data;
         2'd1:    w_grantData = fifo1_data;
         2'd2:    w_grantData = fifo2_data;
         default: w_grantData = fifo3_data;
      endcase
   end

   assign pop0 = w_grant[0];
   assign pop1 = w_grant[1];
   assign pop2 = w_grant[2];
   assign pop3 = w_grant[3];

   // Single state/datapath register block. A grant moves the head word into
   // the output register, bumps that source's counter and points the
   // round-robin just past the winner. Without a grant data_out holds.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_state <= ST_IDLE;
         r_rr    <= 2'd0;
         r_push  <= 1'b0;
         r_data  <= '0;
         for (int i = 0; i < 4; i++) begin
            r_cont[i] <= '0;
         end
      end else if (w_found) begin
         r_data               <= w_grantData;
         r_push               <= 1'b1;
         r_cont[w_grantIdx]   <= r_cont[w_grantIdx] + CNT_SIZE'(1);
         r_rr                 <= w_grantIdx + 2'd1;
         r_state              <= ST_ACTIVE;
      end else begin
         r_push <= 1'b0;
         if ((|w_nonEmpty) && out_almost_full) begin
            r_state <= ST_BLOCKED;
         end else begin
            r_state <= ST_IDLE;
         end
      end
   end

   assign push_out = r_push;
   assign data_out = r_data;
   assign cont0    = r_cont[0];
   assign cont1    = r_cont[1];
   assign cont2    = r_cont[2];
   assign cont3    = r_cont[3];
   assign idle     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_arbitro_salida.sv
// ---------------------------------------------------------------------------
// tb_arbitro_salida
// Bench for arbitro_salida. The four source FIFOs are modelled as queues
// owned by the bench; a behavioural model walks the round-robin rule over
// those queues to predict pops, pushes, data and counters every cycle.
// Directed scenarios add literal expectations, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_arbitro_salida;

   localparam int DW = 12;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          reset_L;
   logic [DW-1:0] fifoData [4];
   logic [3:0]    fifoEmpty;
   logic          outAlmostFull;
   logic          pop0, pop1, pop2, pop3;
   logic          push_out;
   logic [DW-1:0] data_out;
   logic [CW-1:0] cont0, cont1, cont2, cont3;
   logic          idle;

   always #5 clk = ~clk;

   arbitro_salida #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .fifo0_data      (fifoData[0]),
      .fifo1_data      (fifoData[1]),
      .fifo2_data      (fifoData[2]),
      .fifo3_data      (fifoData[3]),
      .fifo0_empty     (fifoEmpty[0]),
      .fifo1_empty     (fifoEmpty[1]),
      .fifo2_empty     (fifoEmpty[2]),
      .fifo3_empty     (fifoEmpty[3]),
      .out_almost_full (outAlmostFull),
      .pop0            (pop0),
      .pop1            (pop1),
      .pop2            (pop2),
      .pop3            (pop3),
      .push_out        (push_out),
      .data_out        (data_out),
      .cont0           (cont0),
      .cont1           (cont1),
      .cont2           (cont2),
      .cont3           (cont3),
      .idle            (idle)
   );

   // Behavioural model state: source FIFO contents, next source to favour,
   // and the registered outputs expected after the next edge.
   logic [DW-1:0] srcQ [4][$];
   int            expRr;
   logic          expPush;
   logic [DW-1:0] expData;
   logic [CW-1:0] expCont [4];
   int            expState;
   bit            modelValid;
   logic [3:0]    lastPops;
   logic [DW-1:0] outLog [$];

   int nVectors;
   int nMiscompares;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Registered outputs are compared at the falling edge, well away from the
   // posedge that updated them.
   task automatic checkOutput();
      logic [CW-1:0] act [4];
      act[0] = cont0; act[1] = cont1; act[2] = cont2; act[3] = cont3;
      if (modelValid) begin
         compare("push_out", {31'd0, push_out}, {31'd0, expPush});
         compare("data_out", {20'd0, data_out}, {20'd0, expData});
         for (int i = 0; i < 4; i++) begin
            compare($sformatf("cont%0d", i), {27'd0, act[i]}, {27'd0, expCont[i]});
         end
         compare("idle", {31'd0, idle}, {31'd0, (expState == 0)});
      end
      if (push_out === 1'b1) begin
         outLog.push_back(data_out);
      end
   endtask

   // Drives one cycle's inputs from the queues, checks the combinational pop
   // strobes against the round-robin rule, and advances the model.
   task automatic applyStimulus(input logic rst, input logic af);
      int         g;
      bit         anyNonEmpty;
      logic [3:0] expPops;
      reset_L       = rst;
      outAlmostFull = af;
      anyNonEmpty   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fifoEmpty[i] = (srcQ[i].size() == 0);
         fifoData[i]  = (srcQ[i].size() != 0) ? srcQ[i][0] : '0;
         if (srcQ[i].size() != 0) anyNonEmpty = 1'b1;
      end
      #1;
      g = -1;
      if (rst && !af) begin
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && srcQ[(expRr + k) % 4].size() != 0) g = (expRr + k) % 4;
         end
      end
      expPops  = (g >= 0) ? 4'(1 << g) : 4'b0000;
      lastPops = {pop3, pop2, pop1, pop0};
      compare("pops", {28'd0, lastPops}, {28'd0, expPops});
      if (!rst) begin
         expPush  = 1'b0;
         expData  = '0;
         expRr    = 0;
         expState = 0;
         for (int i = 0; i < 4; i++) expCont[i] = '0;
         modelValid = 1'b1;
      end else if (g >= 0) begin
         expData    = srcQ[g].pop_front();
         expPush    = 1'b1;
         expCont[g] = expCont[g] + 1'b1;
         expRr      = (g + 1) % 4;
         expState   = 1;
      end else begin
         expPush  = 1'b0;
         expState = (anyNonEmpty && af) ? 2 : 0;
      end
   endtask

   task automatic runCycle(input logic rst, input logic af);
      checkOutput();
      applyStimulus(rst, af);
      @(negedge clk);
   endtask

   task automatic clearAll();
      for (int i = 0; i < 4; i++) srcQ[i].delete();
      runCycle(1'b0, 1'b0);
      outLog.delete();
   endtask

   initial begin
      logic [DW-1:0] t3Words [4];
      nVectors      = 0;
      nMiscompares  = 0;
      modelValid    = 1'b0;
      expRr         = 0;
      reset_L       = 1'b0;
      outAlmostFull = 1'b0;
      fifoEmpty     = 4'hF;
      for (int i = 0; i < 4; i++) fifoData[i] = '0;
      @(negedge clk);

      // 1: reset held for two cycles with every FIFO holding a word
      for (int i = 0; i < 4; i++) srcQ[i].push_back(DW'(12'h100 * i));
      runCycle(1'b0, 1'b0);
      runCycle(1'b0, 1'b0);
      compare("t1 idle", {31'd0, idle}, 32'd1);
      compare("t1 push_out", {31'd0, push_out}, 32'd0);
      compare("t1 cont0", {27'd0, cont0}, 32'd0);

      // 2: single source FIFO2 with three words
      clearAll();
      srcQ[2].push_back(12'h812);
      srcQ[2].push_back(12'h81C);
      srcQ[2].push_back(12'h826);
      for (int c = 0; c < 6; c++) runCycle(1'b1, 1'b0);
      checkOutput();
      compare("t2 count", outLog.size(), 32'd3);
      if (outLog.size() == 3) begin
         compare("t2 word0", {20'd0, outLog[0]}, 32'h812);
         compare("t2 word1", {20'd0, outLog[1]}, 32'h81C);
         compare("t2 word2", {20'd0, outLog[2]}, 32'h826);
      end
      compare("t2 cont2", {27'd0, cont2}, 32'd3);
      compare("t2 idle", {31'd0, idle}, 32'd1);

      // 3: round-robin, two words per FIFO
      clearAll();
      t3Words[0] = 12'h3FF; t3Words[1] = 12'h7FF; t3Words[2] = 12'hBFF; t3Words[3] = 12'hFFF;
      for (int i = 0; i < 4; i++) begin
         srcQ[i].push_back(t3Words[i]);
         srcQ[i].push_back(t3Words[i]);
      end
      for (int c = 0; c < 10; c++) runCycle(1'b1, 1'b0);
      compare("t3 count", outLog.size(), 32'd8);
      if (outLog.size() == 8) begin
         for (int n = 0; n < 8; n++) begin
            compare($sformatf("t3 order%0d", n), {20'd0, outLog[n]}, {20'd0, t3Words[n % 4]});
         end
      end
      compare("t3 cont0", {27'd0, cont0}, 32'd2);
      compare("t3 cont3", {27'd0, cont3}, 32'd2);

      // 4: backpressure for three cycles mid-stream
      clearAll();
      for (int i = 0; i < 4; i++) begin
         for (int n = 0; n < 4; n++) srcQ[i].push_back(DW'({i[1:0], 10'(n)}));
      end
      for (int c = 0; c < 3; c++) runCycle(1'b1, 1'b0);
      for (int c = 0; c < 3; c++) runCycle(1'b1, 1'b1);
      compare("t4 blocked not idle", {31'd0, idle}, 32'd0);
      for (int c = 0; c < 16; c++) runCycle(1'b1, 1'b0);
      compare("t4 count", outLog.size(), 32'd16);

      // 5: counter wrap through FIFO1
      clearAll();
      for (int n = 0; n < 33; n++) srcQ[1].push_back(DW'({2'b01, 10'(n)}));
      for (int c = 0; c < 36; c++) runCycle(1'b1, 1'b0);
      compare("t5 cont1", {27'd0, cont1}, 32'd1);
      compare("t5 count", outLog.size(), 32'd33);
      if (outLog.size() == 33) begin
         for (int n = 0; n < 33; n++) begin
            compare($sformatf("t5 word%0d", n), {20'd0, outLog[n]}, {20'd0, 2'b01, 10'(n)});
         end
      end

      // 6: one-cycle reset while FIFO0 and FIFO3 hold words
      clearAll();
      for (int n = 0; n < 3; n++) srcQ[0].push_back(DW'(12'h010 + n));
      for (int n = 0; n < 2; n++) srcQ[3].push_back(DW'(12'hC10 + n));
      runCycle(1'b1, 1'b0);
      compare("t6 first pop", {28'd0, lastPops}, 32'h1);
      runCycle(1'b0, 1'b0);
      compare("t6 reset pop", {28'd0, lastPops}, 32'h0);
      runCycle(1'b1, 1'b0);
      compare("t6 grant after release", {28'd0, lastPops}, 32'h1);
      for (int c = 0; c < 6; c++) runCycle(1'b1, 1'b0);

      // Randomized traffic, backpressure and occasional resets
      clearAll();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (($urandom % 10) < 3 && srcQ[i].size() < 6) begin
               srcQ[i].push_back(DW'({i[1:0], 10'($urandom)}));
            end
         end
         runCycle(($urandom % 200) != 0, ($urandom % 4) == 0);
      end
      checkOutput();

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/arbitro_salida.md
Name: arbitro_salida

Overview:
- 4-to-1 merging arbiter that reads four class FIFOs and forwards their words into a single output FIFO.
- It is the read side of the routing arbiter, which splits the main queue into four FIFOs by data_in[11:10].
- It drains the four FIFOs round-robin, one word per cycle, under almost-full backpressure from the output FIFO.
- It keeps per-source word counters for the bench to compare against push counts on the write side.

Parameters:
DATA_SIZE  12  width of each data word
CNT_SIZE   5   width of each per-source word counter

Ports:
clk               input   1          single clock; all state updates on posedge
reset_L           input   1          synchronous, active-low reset
fifo0_data        input   DATA_SIZE  head word of FIFO 0 (show-ahead: valid whenever fifo0_empty=0)
fifo1_data        input   DATA_SIZE  head word of FIFO 1
fifo2_data        input   DATA_SIZE  head word of FIFO 2
fifo3_data        input   DATA_SIZE  head word of FIFO 3
fifo0_empty..fifo3_empty  input  1 each  empty flags of the four source FIFOs
out_almost_full   input   1          almost-full flag of the output FIFO
pop0..pop3        output  1 each     pop strobes to the source FIFOs (combinational, one-hot or zero)
push_out          output  1          write strobe to the output FIFO (registered)
data_out          output  DATA_SIZE  word to the output FIFO (registered)
cont0..cont3      output  CNT_SIZE each  words forwarded from each source
idle              output  1          high while in state IDLE

Behaviour:
- Clock and reset: one clock. reset_L is synchronous and active-low, sampled on posedge clk.
- Reset values (reset_L=0 at a posedge):
  - push_out=0, data_out=0, cont0..cont3=0, idle=1.
  - Round-robin pointer rr=0, state=IDLE.
  - pop0..pop3 are forced to 0 combinationally whenever reset_L=0, including mid-operation.
- States:
  - IDLE: no source eligible.
  - ACTIVE: a grant is issued this cycle.
  - BLOCKED: some source is non-empty but out_almost_full=1.
  - idle=1 only in IDLE. The state is registered and reflects the previous cycle's decision.
- Eligibility: source i is eligible when fifo_i_empty=0 and out_almost_full=0.
- Grant (combinational in cycle k):
  - Search i = rr, rr+1, rr+2, rr+3 (mod 4). The first eligible source wins.
  - Assert pop_i=1 for that source only. At most one pop per cycle.
- At the posedge ending cycle k, with a grant to i:
  - data_out <= fifo_i_data, push_out <= 1.
  - cont_i <= cont_i + 1, wrapping 31->0 with no saturation.
  - rr <= (i+1) mod 4; state <= ACTIVE.
- At the posedge ending cycle k, with no grant:
  - push_out <= 0; data_out holds its value; rr holds.
  - state <= BLOCKED if any fifo_i_empty=0 and out_almost_full=1, otherwise IDLE.
- Latency: pop in cycle k gives the word on data_out with push_out=1 in cycle k+1.
- Throughput: 1 word/cycle with no bubbles while eligible sources exist.
- Backpressure: out_almost_full=1 in cycle k gives zero pops in cycle k.
  - The push for a pop made in cycle k-1 still completes in cycle k.
  - out_almost_full must therefore be set at least one entry below true full.
- Empty boundary:
  - Pops use the current cycle's empty flags. A FIFO holding 1 word is popped once and is not eligible next cycle, because its empty flag rises on the same edge.
  - Never pop an empty FIFO.
- Fairness: with all four sources continuously non-empty, the grant order is 0,1,2,3,0,... and no source waits more than 3 cycles.
- Simultaneous events:
  - Several sources becoming non-empty in the same cycle are served in rr order.
  - out_almost_full falling and a source filling in the same cycle gives a pop in that same cycle.
- Reset mid-stream: the pop in the reset cycle is suppressed. On the next cycle push_out=0 and the counters are 0. Pending FIFO contents are untouched.
- Data is forwarded unmodified; the routing bits [11:10] are preserved.

Test Plan:
1. Reset: hold reset_L=0 for 2 cycles with all FIFOs non-empty -> pop0..3=0 throughout, push_out=0, cont*=0, idle=1.
2. Single source: FIFO2 holds 0x812, 0x81C, 0x826 -> pop2 in cycles k..k+2, then data_out=0x812/0x81C/0x826 with push_out=1 in cycles k+1..k+3, cont2=3, then idle=1.
3. Round-robin: FIFOs 0..3 each hold 2 words (0x3FF, 0x7FF, 0xBFF, 0xFFF) -> 8 consecutive pushes in source order 0,1,2,3,0,1,2,3; cont0..3=2 each.
4. Backpressure: raise out_almost_full for 3 cycles mid-stream -> pops stop in the same cycle, exactly one trailing push, state=BLOCKED, no words lost or duplicated; the stream resumes at the next rr source.
5. Counter wrap: push 33 words through FIFO1 -> cont1=1 and the output word sequence is intact.
6. Reset mid-operation: assert reset_L=0 for 1 cycle while FIFO0 and FIFO3 are non-empty -> no pop that cycle, rr=0 afterwards, and the first grant after release goes to FIFO0.
